hex_display_scheduler: RTL and testbench
========================================

# hex_display_scheduler

Shares the board's four hex digits between up to NUM_SRC 16-bit debug sources (bus, PC, IR, accumulator) and selects the visible page from a debounced push-button or an auto-rotate timer. Pages whose source is not valid are skipped. Output is a registered snapshot of four nibbles plus per-digit blanking. Its outputs drive four `binary_to_7seg` instances, and `page` drives the page-indicator digit.

## Interface
- NUM_SRC, 4: number of sources, 2..8
- DEBOUNCE_CYCLES, 500000: stable-level time for the button (10 ms at 50 MHz)
- ROTATE_CYCLES, 50000000: auto-rotate period (1 s at 50 MHz)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- src_data  in  16*NUM_SRC  source i occupies bits [16i+15:16i]
- src_valid  in  NUM_SRC  source i currently displayable
- next_btn_n  in  1  raw active-low KEY input, asynchronous to clk
- auto_en  in  1  enable auto-rotate
- freeze  in  1  hold snapshot and page
- blank_lz  in  1  blank leading-zero digits
- digit_nib  out  16  nibble per digit, digit 0 = bits [3:0]
- digit_blank  out  4  1 = digit dark
- page  out  $clog2(NUM_SRC)  selected source index
- page_valid  out  1  snapshot reflects a valid source

## Operation
- Button path: 2-flop synchronizer, then a counter that accepts the new level only after DEBOUNCE_CYCLES consecutive equal samples. A 1→0 accepted transition produces a one-cycle `press` pulse.
- Rotate timer: counts while auto_en=1, state=SHOW and freeze=0. Expiry (count = ROTATE_CYCLES-1) produces a one-cycle `tick`. The timer clears on any advance, on auto_en=0, on freeze=1, and outside SHOW.
- advance = (press | tick) & ~freeze. Press and tick in the same cycle count as one advance. Press while frozen is discarded, not queued.
- FSM states:
  - SEEK: if src_valid[page], go to SHOW. Otherwise page ← page+1 (wraps at NUM_SRC-1 → 0) and seek_cnt+1. When seek_cnt reaches NUM_SRC-1 with no hit, go to EMPTY. Because page has wrapped, it returns to its SEEK-entry value.
  - SHOW: each cycle with freeze=0, snapshot ← src_data[page]. If src_valid[page] falls (freeze=0), go to SEEK. On advance, page ← page+1 and go to SEEK.
  - EMPTY: page_valid=0, all digits blank. Any src_valid bit set moves to SEEK with seek_cnt=0.
- seek_cnt clears on every entry to SEEK.
- freeze=1 in SHOW holds snapshot, page and state regardless of src_valid. On release, SHOW resumes normal operation.
- Blanking:
  - With blank_lz=1, digit k (k≥1) is blank when its nibble and all higher nibbles are 0. Digit 0 is never blanked in SHOW.
  - With blank_lz=0, no digits are blanked in SHOW.
  - digit_blank=4'hF outside SHOW.

## Timing
- Reset values:
  - state=SEEK, page=0, seek_cnt=0
  - snapshot/digit_nib=16'h0, digit_blank=4'hF, page_valid=0
  - debounce level=1 (released), counters 0
- Press latency: press pulses DEBOUNCE_CYCLES+2 cycles after the raw edge, since synchronizer flops precede the counter.
- Advance latency:
  - Cycle N: advance asserted.
  - N+1: SEEK with page=p+1.
  - N+2: SHOW if p+1 is valid.
  - N+3: digit_nib shows the new source.
- Worst-case seek: NUM_SRC cycles to SHOW or EMPTY.
- page_valid=1 exactly when state=SHOW, registered with the state.
- Data latency in SHOW: one cycle, from src_data to digit_nib.
- Reset asserted mid-seek or mid-debounce returns to reset values immediately. No pending press survives reset.

## Structure
- Package `display_pkg`: state enum {SEEK, SHOW, EMPTY} and localparam for the page-index width.
- Sub-module `button_debouncer` (synchronizer, debounce counter, falling-edge pulse). It is reusable for the other KEY inputs.
- Scheduler FSM, rotate timer, snapshot and leading-zero blank logic stay in `hex_display_scheduler`.

## Test plan
Bench parameters: NUM_SRC=4, DEBOUNCE_CYCLES=4, ROTATE_CYCLES=16.
- Reset release with src_valid=4'b1111 and src0=16'h1234 → SEEK, then SHOW page 0. digit_nib=16'h1234 on the 3rd cycle after release; page_valid=1.
- src_valid=4'b1001, pulse next_btn_n low for 10 cycles → one press. Page skips 1 and 2 and settles on 3 within 4 cycles. A 2-cycle glitch produces no press.
- src_valid=4'b0000 from reset → EMPTY after 4 SEEK cycles with page=0 and digit_blank=4'hF. Setting src_valid[2] → SHOW page 2.
- auto_en=1, all valid, freeze=0 → page increments every 16+2 cycles, 0→1→2→3→0. Press coinciding with tick → single increment.
- In SHOW page 1, freeze=1, change src1 and drop src_valid[1], press button → digit_nib, page and state unchanged. Release → SEEK to page 2.
- blank_lz=1, src=16'h00A0 → digit_blank=4'b1100. src=16'h0000 → 4'b1110. blank_lz=0 → 4'b0000.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// display_pkg - shared state type and helpers for the hex display scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      SHOW  = 2'd1,
      EMPTY = 2'd2
   } state_e;

   localparam int unsigned PAGE_W_MAX = 3;

   function automatic int unsigned page_width(input int unsigned n);
      int unsigned w;
      w = (n < 2) ? 1 : $clog2(n);
      return (w > PAGE_W_MAX) ? PAGE_W_MAX : w;
   endfunction

   // Digit k blanks when it and every more significant nibble are zero.
   function automatic logic [3:0] lz_blank(input logic [15:0] v, input logic en);
      logic [3:0] b;
      b[3] = en & (v[15:12] == 4'h0);
      b[2] = b[3] & (v[11:8] == 4'h0);
      b[1] = b[2] & (v[7:4] == 4'h0);
      b[0] = 1'b0;
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_debouncer - synchronize, debounce and pulse on press of an active-low KEY
// Rev 1.0
// ----------------------------------------------------------------------------
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n_i,
   output logic press_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_n_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   // Any sample equal to the accepted level restarts the stability count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            press_d = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/hex_display_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hex_display_scheduler - pages four hex digits across several 16-bit debug sources
// Rev 1.0
// ----------------------------------------------------------------------------
module hex_display_scheduler
   import display_pkg::*;
#(
   parameter int unsigned NUM_SRC         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ROTATE_CYCLES   = 50000000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [16*NUM_SRC-1:0]             src_data,
   input  logic [NUM_SRC-1:0]                src_valid,
   input  logic                              next_btn_n,
   input  logic                              auto_en,
   input  logic                              freeze,
   input  logic                              blank_lz,
   output logic [15:0]                       digit_nib,
   output logic [3:0]                        digit_blank,
   output logic [page_width(NUM_SRC)-1:0]    page,
   output logic                              page_valid
);

   localparam int unsigned       PAGE_W    = page_width(NUM_SRC);
   localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_SRC - 1);
   localparam int unsigned       ROT_W     = $clog2(ROTATE_CYCLES + 1);
   localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROTATE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [PAGE_W-1:0] page_q, page_d;
   logic [PAGE_W-1:0] seek_cnt_q, seek_cnt_d;
   logic [15:0]       snap_q, snap_d;
   logic              page_valid_q;
   logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
   logic              tick_q, tick_d;

   logic              press_w;
   logic              advance_w;
   logic              rot_run_w;
   logic              cur_valid_w;
   logic [15:0]       cur_data_w;
   logic [PAGE_W-1:0] page_inc_w;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_next_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (next_btn_n),
      .press_o (press_w)
   );

   assign cur_data_w  = src_data[{page_q, 4'h0} +: 16];
   assign cur_valid_w = src_valid[page_q];
   assign page_inc_w  = (page_q == LAST_PAGE) ? '0 : page_q + PAGE_W'(1);
   assign advance_w   = (press_w | tick_q) & ~freeze;
   assign rot_run_w   = auto_en & (state_q == SHOW) & ~freeze & ~advance_w;

   // The tick is registered, so one rotate period is ROTATE_CYCLES in SHOW
   // plus the advance cycle and the SEEK cycle.
   always_comb begin
      rot_cnt_d = '0;
      tick_d    = 1'b0;
      if (rot_run_w) begin
         if (rot_cnt_q == ROT_LAST) begin
            tick_d = 1'b1;
         end else begin
            rot_cnt_d = rot_cnt_q + ROT_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      seek_cnt_d = seek_cnt_q;
      snap_d     = snap_q;
      case (state_q)
         SEEK: begin
            if (cur_valid_w) begin
               state_d = SHOW;
            end else begin
               page_d     = page_inc_w;
               seek_cnt_d = seek_cnt_q + PAGE_W'(1);
               if (seek_cnt_q == LAST_PAGE) begin
                  state_d    = EMPTY;
                  seek_cnt_d = '0;
               end
            end
         end
         SHOW: begin
            if (!freeze) begin
               snap_d = cur_data_w;
               if (advance_w) begin
                  page_d     = page_inc_w;
                  state_d    = SEEK;
                  seek_cnt_d = '0;
               end else if (!cur_valid_w) begin
                  state_d    = SEEK;
                  seek_cnt_d = '0;
               end
            end
         end
         EMPTY: begin
            if (|src_valid) begin
               state_d    = SEEK;
               seek_cnt_d = '0;
            end
         end
         default: begin
            state_d    = SEEK;
            seek_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SEEK;
         page_q       <= '0;
         seek_cnt_q   <= '0;
         snap_q       <= 16'h0;
         page_valid_q <= 1'b0;
         rot_cnt_q    <= '0;
         tick_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         page_q       <= page_d;
         seek_cnt_q   <= seek_cnt_d;
         snap_q       <= snap_d;
         page_valid_q <= (state_d == SHOW);
         rot_cnt_q    <= rot_cnt_d;
         tick_q       <= tick_d;
      end
   end

   assign digit_nib   = snap_q;
   assign digit_blank = (state_q == SHOW) ? lz_blank(snap_q, blank_lz) : 4'hF;
   assign page        = page_q;
   assign page_valid  = page_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hex_display_scheduler - directed/randomized self-checking bench
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hex_display_scheduler;

   localparam int N = 4;
   localparam int D = 4;
   localparam int R = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [16*N-1:0] src_data;
   logic [N-1:0]    src_valid;
   logic            next_btn_n;
   logic            auto_en;
   logic            freeze;
   logic            blank_lz;
   logic [15:0]     digit_nib;
   logic [3:0]      digit_blank;
   logic [1:0]      page;
   logic            page_valid;

   logic [15:0]     src [N];
   int              errors = 0;
   int              checks = 0;

   always #5 clk = ~clk;

   always_comb begin
      src_data = '0;
      for (int i = 0; i < N; i++) src_data[16*i +: 16] = src[i];
   end

   hex_display_scheduler #(
      .NUM_SRC         (N),
      .DEBOUNCE_CYCLES (D),
      .ROTATE_CYCLES   (R)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .next_btn_n  (next_btn_n),
      .auto_en     (auto_en),
      .freeze      (freeze),
      .blank_lz    (blank_lz),
      .digit_nib   (digit_nib),
      .digit_blank (digit_blank),
      .page        (page),
      .page_valid  (page_valid)
   );

   // First displayable page found scanning upward (with wrap) from start.
   function automatic int exp_page(input int start, input logic [N-1:0] mask);
      for (int i = 0; i < N; i++)
         if (mask[(start + i) % N]) return (start + i) % N;
      return start;
   endfunction

   function automatic logic [3:0] exp_blank(input logic [15:0] v, input bit lz);
      logic [3:0] b;
      b = 4'b0000;
      for (int k = 1; k < 4; k++) b[k] = lz && ((v >> (4 * k)) == 16'h0);
      return b;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pv(input int bound, output bit ok);
      int n;
      n = 0;
      while (!page_valid && n < bound) begin
         step(1);
         n++;
      end
      ok = page_valid;
   endtask

   // Edges from now until page_valid next rises.
   task automatic wait_rise(input int bound, output int n, output bit ok);
      n = 0;
      while (page_valid && n < bound) begin
         step(1);
         n++;
      end
      while (!page_valid && n < bound) begin
         step(1);
         n++;
      end
      ok = page_valid && (n < bound);
   endtask

   task automatic press_btn();
      next_btn_n = 1'b0;
      step(10);
      next_btn_n = 1'b1;
      step(D + 4);
   endtask

   initial begin
      bit          ok;
      int          n;
      int          cur;
      logic [15:0] v;
      logic [15:0] held;

      rst        = 1'b1;
      src[0]     = 16'h1234;
      for (int i = 1; i < N; i++) src[i] = 16'($urandom);
      src_valid  = 4'b1111;
      next_btn_n = 1'b1;
      auto_en    = 1'b0;
      freeze     = 1'b0;
      blank_lz   = 1'b0;
      step(3);
      chk("reset_nib", digit_nib, 16'h0);
      chk("reset_blank", digit_blank, 4'hF);
      chk("reset_page", page, 0);
      chk("reset_pv", page_valid, 0);

      rst = 1'b0;
      step(1);
      chk("release_pv", page_valid, 1);
      chk("release_page", page, 0);
      step(1);
      chk("release_nib", digit_nib, 16'h1234);
      chk("release_blank", digit_blank, exp_blank(16'h1234, 0));

      blank_lz = 1'b1;
      src[0]   = 16'h00A0;
      step(2);
      chk("lz_00A0", digit_blank, exp_blank(16'h00A0, 1));
      src[0] = 16'h0000;
      step(2);
      chk("lz_0000", digit_blank, exp_blank(16'h0000, 1));
      blank_lz = 1'b0;
      step(1);
      chk("lz_off", digit_blank, exp_blank(16'h0000, 0));
      for (int t = 0; t < 6; t++) begin
         v = 16'($urandom);
         for (int k = 0; k < 4; k++) if ($urandom_range(1, 0) == 0) v[4*k +: 4] = 4'h0;
         src[0]   = v;
         blank_lz = 1'($urandom_range(1, 0));
         step(2);
         chk("rand_nib", digit_nib, v);
         chk("rand_blank", digit_blank, exp_blank(v, blank_lz));
      end

      // A press begun before reset must not survive it.
      blank_lz   = 1'b0;
      next_btn_n = 1'b0;
      step(3);
      rst        = 1'b1;
      next_btn_n = 1'b1;
      step(2);
      chk("midrst_page", page, 0);
      chk("midrst_blank", digit_blank, 4'hF);
      rst = 1'b0;
      step(3 * D + 10);
      chk("postrst_page", page, 0);
      chk("postrst_pv", page_valid, 1);

      src_valid  = 4'b1001;
      step(1);
      next_btn_n = 1'b0;
      step(D + 2);
      chk("press_pre_page", page, 0);
      chk("press_pre_pv", page_valid, 1);
      step(1);
      chk("press_seek_page", page, 1);
      chk("press_seek_pv", page_valid, 0);
      step(3);
      next_btn_n = 1'b1;
      wait_pv(N + 2, ok);
      chk("skip_settle", ok, 1);
      chk("skip_page", page, exp_page(1, src_valid));
      step(1);
      chk("skip_nib", digit_nib, src[exp_page(1, src_valid)]);
      step(D + 4);
      chk("release_no_press", page, exp_page(1, src_valid));
      next_btn_n = 1'b0;
      step(2);
      next_btn_n = 1'b1;
      step(D + 6);
      chk("glitch_page", page, exp_page(1, src_valid));
      chk("glitch_pv", page_valid, 1);

      rst       = 1'b1;
      src_valid = 4'b0000;
      step(2);
      rst = 1'b0;
      step(3);
      chk("seek_blank", digit_blank, 4'hF);
      chk("seek_pv", page_valid, 0);
      step(1);
      chk("empty_page", page, 0);
      chk("empty_blank", digit_blank, 4'hF);
      step(3);
      chk("empty_hold_page", page, 0);
      chk("empty_hold_pv", page_valid, 0);
      src[2]    = 16'($urandom);
      src_valid = 4'b0100;
      wait_pv(N + 2, ok);
      chk("wake_settle", ok, 1);
      chk("wake_page", page, exp_page(0, src_valid));
      step(1);
      chk("wake_nib", digit_nib, src[2]);

      src_valid = 4'b1111;
      auto_en   = 1'b1;
      wait_rise(60, n, ok);
      chk("rot_sync", ok, 1);
      cur = int'(page);
      for (int it = 0; it < 4; it++) begin
         wait_rise(60, n, ok);
         chk("rot_ok", ok, 1);
         chk("rot_period", n, R + 2);
         chk("rot_page", page, (cur + 1) % N);
         cur = int'(page);
      end
      // Press timed to land on the same cycle as the rotate tick.
      step(10);
      next_btn_n = 1'b0;
      wait_rise(60, n, ok);
      next_btn_n = 1'b1;
      chk("coinc_ok", ok, 1);
      chk("coinc_period", n, R + 2 - 10);
      chk("coinc_page", page, (cur + 1) % N);
      cur = int'(page);
      wait_rise(60, n, ok);
      chk("after_coinc_period", n, R + 2);
      chk("after_coinc_page", page, (cur + 1) % N);

      auto_en = 1'b0;
      step(2);
      for (int i = 0; i < N; i++) if (page != 2'd1) press_btn();
      wait_pv(N + 2, ok);
      chk("goto1_page", page, 1);
      chk("goto1_pv", page_valid, 1);
      held = src[1];
      step(1);
      chk("goto1_nib", digit_nib, held);
      freeze = 1'b1;
      step(1);
      src[1]     = ~held;
      src_valid  = 4'b1101;
      next_btn_n = 1'b0;
      step(10);
      next_btn_n = 1'b1;
      step(D + 4);
      chk("frz_nib", digit_nib, held);
      chk("frz_page", page, 1);
      chk("frz_pv", page_valid, 1);
      chk("frz_blank", digit_blank, exp_blank(held, 0));
      freeze = 1'b0;
      wait_rise(N + 6, n, ok);
      chk("unfrz_ok", ok, 1);
      chk("unfrz_page", page, exp_page(2, src_valid));
      step(1);
      chk("unfrz_nib", digit_nib, src[exp_page(2, src_valid)]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
